// File: rtl/alu_cmd_master.sv
// Command initiator for the operand/result ALU port: issues accepted commands,
// tracks them through a latency-matched tag pipeline and queues results in order.
module alu_cmd_master #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_cin,
  input  logic [3:0]        cmd_ctl,
  output logic              valid_in,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              cin,
  output logic [3:0]        ctl,
  input  logic              valid_out,
  input  logic [DATA_W-1:0] alu,
  input  logic              carry,
  input  logic              zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_alu,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [3:0]        rsp_ctl,
  output logic              rsp_err,
  output logic              proto_err,
  output logic [15:0]       issue_cnt
);

  // Both ports use strict valid/ready: a transfer happens on a rising edge where
  // valid && ready; valid never depends on ready, and cmd_ready never looks at cmd_valid.

  localparam int PW  = $clog2(DEPTH);
  localparam int NST = ALU_LAT + 1;
  localparam int SW  = $clog2(DEPTH + NST + 1) + 1;

  typedef struct packed {
    logic       vld;
    logic       err;
    logic [3:0] ctl;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic              carry;
    logic              zero;
    logic [3:0]        ctl;
    logic              err;
  } ent_t;

  // Stage 0 is loaded in parallel with the ALU input register, so the last
  // stage lines up with the cycle in which that issue's valid_out is due.
  tag_t          tag_pipe [NST];
  ent_t          mem      [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [SW-1:0] inflight;
  logic [SW-1:0] used;
  logic [2:0]    ign_cnt;
  tag_t          head;
  ent_t          push_ent;
  logic          accept;
  logic          legal;
  logic          push;
  logic          pop;
  logic          full;
  logic          proto_set;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NST; i++) inflight = inflight + SW'(tag_pipe[i].vld);
  end

  // Credit is taken from registered state only, so a pop frees a slot one cycle later.
  assign used      = SW'(count) + inflight;
  assign cmd_ready = !reset && (used < SW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = cmd_ctl < 4'd14;

  assign head      = tag_pipe[NST-1];
  assign push      = head.vld;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign full      = (count == (PW+1)'(DEPTH));

  always_comb begin
    push_ent     = '0;
    push_ent.ctl = head.ctl;
    if (head.err) begin
      push_ent.zero = 1'b1;
      push_ent.err  = 1'b1;
    end else if (valid_out) begin
      push_ent.alu   = alu;
      push_ent.carry = carry;
      push_ent.zero  = zero;
    end else begin
      push_ent.err = 1'b1;
    end
  end

  // Stray results just after reset belong to operations that reset discarded.
  assign proto_set = (head.vld && !head.err && !valid_out) ||
                     (head.vld && head.err && valid_out) ||
                     (!head.vld && valid_out && (ign_cnt == 3'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_in  <= 1'b0;
      a         <= '0;
      b         <= '0;
      cin       <= 1'b0;
      ctl       <= '0;
      issue_cnt <= '0;
      proto_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ign_cnt   <= 3'(ALU_LAT);
      for (int i = 0; i < NST; i++) tag_pipe[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      valid_in <= accept && legal;
      if (accept && legal) begin
        a   <= cmd_a;
        b   <= cmd_b;
        cin <= cmd_cin;
        ctl <= cmd_ctl;
      end
      if (accept) issue_cnt <= issue_cnt + 16'd1;

      if (accept) begin
        tag_pipe[0].vld <= 1'b1;
        tag_pipe[0].err <= !legal;
        tag_pipe[0].ctl <= cmd_ctl;
      end else begin
        tag_pipe[0] <= '0;
      end
      for (int i = 1; i < NST; i++) tag_pipe[i] <= tag_pipe[i-1];

      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase

      if (proto_set) proto_err <= 1'b1;
      if (ign_cnt != 3'd0) ign_cnt <= ign_cnt - 3'd1;
    end
  end

  assign rsp_alu   = mem[rd_ptr].alu;
  assign rsp_carry = mem[rd_ptr].carry;
  assign rsp_zero  = mem[rd_ptr].zero;
  assign rsp_ctl   = mem[rd_ptr].ctl;
  assign rsp_err   = mem[rd_ptr].err;

  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master: a small latency-ALU_LAT ALU model on the
// operand port, an in-order response scoreboard, table vectors and corner sequences.
module tb_alu_cmd_master;

  localparam int DATA_W  = 4;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int EW      = DATA_W + 7;

  logic              clk_tb = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_cin;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [3:0]        cmd_ctl;
  logic              valid_in, cin;
  logic [DATA_W-1:0] a, b;
  logic [3:0]        ctl;
  logic              valid_out, carry, zero;
  logic [DATA_W-1:0] alu;
  logic              rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err;
  logic [DATA_W-1:0] rsp_alu;
  logic [3:0]        rsp_ctl;
  logic              proto_err;
  logic [15:0]       issue_cnt;
  logic              drop, spur;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vin_cnt  = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [3:0]        op;
    logic [DATA_W-1:0] av;
    logic [DATA_W-1:0] bv;
    logic              ci;
    logic [DATA_W-1:0] e_alu;
    logic              e_c;
    logic              e_z;
    logic              e_err;
  } vec_t;
  vec_t vecs [9];

  // ---------------- clock / reset ----------------
  always #5 clk_tb = ~clk_tb;
  always @(posedge clk_tb) cyc <= cyc + 1;
  always @(negedge clk_tb) if (valid_in) vin_cnt <= vin_cnt + 1;

  alu_cmd_master #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk_tb), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_ctl(cmd_ctl),
    .valid_in(valid_in), .a(a), .b(b), .cin(cin), .ctl(ctl),
    .valid_out(valid_out), .alu(alu), .carry(carry), .zero(zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_alu(rsp_alu), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_ctl(rsp_ctl), .rsp_err(rsp_err),
    .proto_err(proto_err), .issue_cnt(issue_cnt)
  );

  // ---------------- ALU model (0 SEL,1 INC,2 DEC,3 ADD,4 SUB,5 XOR,6 AND,7 OR) ----------------
  function automatic logic [DATA_W:0] alu_fn(input logic [3:0] op, input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y, input logic ci);
    logic [DATA_W:0] xe, ye, r;
    xe = {1'b0, x};
    ye = {1'b0, y};
    case (op)
      4'd0:    r = ye;
      4'd1:    r = xe + (DATA_W+1)'(1);
      4'd2:    r = xe - (DATA_W+1)'(1);
      4'd3:    r = xe + ye + (DATA_W+1)'(ci);
      4'd4:    r = xe - ye - (DATA_W+1)'(ci);
      4'd5:    r = xe ^ ye;
      4'd6:    r = xe & ye;
      4'd7:    r = xe | ye;
      default: r = xe;
    endcase
    return r;
  endfunction

  logic [DATA_W+1:0] alu_st [ALU_LAT];
  always @(posedge clk_tb or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ALU_LAT; i++) alu_st[i] <= '0;
    end else begin
      alu_st[0] <= {valid_in, alu_fn(ctl, a, b, cin)};
      for (int i = 1; i < ALU_LAT; i++) alu_st[i] <= alu_st[i-1];
    end
  end
  assign valid_out = (alu_st[ALU_LAT-1][DATA_W+1] & ~drop) | spur;
  assign carry     = alu_st[ALU_LAT-1][DATA_W];
  assign alu       = alu_st[ALU_LAT-1][DATA_W-1:0];
  assign zero      = (alu == '0);

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [DATA_W-1:0] r, input logic c, input logic z,
                                       input logic [3:0] op, input logic e);
    return {r, c, z, op, e};
  endfunction

  always @(negedge clk_tb) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected no response",
                 {rsp_alu, rsp_carry, rsp_zero, rsp_ctl, rsp_err});
      end else begin
        check("rsp", 32'({rsp_alu, rsp_carry, rsp_zero, rsp_ctl, rsp_err}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send_cmd(input logic [3:0] op, input logic [DATA_W-1:0] av,
                          input logic [DATA_W-1:0] bv, input logic ci, input logic [EW-1:0] e);
    int n = 0;
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_ctl = op; cmd_a = av; cmd_b = bv; cmd_cin = ci;
    while (!ok && n < 100) begin
      @(negedge clk_tb);
      if (cmd_ready) ok = 1'b1;
      else begin
        @(posedge clk_tb); #1;
        n++;
      end
    end
    if (ok) begin
      exp_q.push_back(e);
      @(posedge clk_tb); #1;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready low for %0d cycles, expected high", n);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(posedge clk_tb); #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk_tb);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0, v0;
    vecs[0] = '{4'd0, 4'd3,  4'd0,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'd1, 4'd15, 4'd0,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'd2, 4'd0,  4'd0,  1'b0, 4'd15, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'd3, 4'd7,  4'd8,  1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'd4, 4'd9,  4'd4,  1'b1, 4'd4,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'd5, 4'd10, 4'd10, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'd6, 4'd12, 4'd10, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'd7, 4'd12, 4'd3,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'd15, 4'd5, 4'd6,  1'b0, 4'd0,  1'b0, 1'b1, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_ctl = '0;
    rsp_ready = 1'b0; drop = 1'b0; spur = 1'b0;

    // Reset state
    #1;
    check("rst_valid_in", 32'(valid_in), 0);
    check("rst_a_b_ctl", 32'({a, b, cin, ctl}), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_fields", 32'({rsp_alu, rsp_carry, rsp_zero, rsp_ctl, rsp_err}), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    check("rst_issue_cnt", 32'(issue_cnt), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    repeat (2) @(posedge clk_tb);
    #1 reset = 1'b0;
    #1 check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk_tb); #1;
    rsp_ready = 1'b1;

    // ADD 9+8 with cycle-exact timing
    cmd_valid = 1'b1; cmd_ctl = 4'd3; cmd_a = 4'd9; cmd_b = 4'd8; cmd_cin = 1'b0;
    @(negedge clk_tb);
    check("add_cmd_ready", 32'(cmd_ready), 1);
    exp_q.push_back(mk(4'd1, 1'b1, 1'b0, 4'd3, 1'b0));
    @(posedge clk_tb); #1;
    cmd_valid = 1'b0;
    check("add_issue", 32'({valid_in, a, b, ctl}), 32'({1'b1, 4'd9, 4'd8, 4'd3}));
    check("add_issue_cnt", 32'(issue_cnt), 1);
    @(posedge clk_tb); #1;
    check("add_idle_valid_in", 32'(valid_in), 0);
    check("add_rsp_early", 32'(rsp_valid), 0);
    check("add_hold_a_b", 32'({a, b}), 32'({4'd9, 4'd8}));
    @(posedge clk_tb); #1;
    check("add_rsp", 32'({rsp_valid, rsp_alu, rsp_carry, rsp_zero, rsp_ctl, rsp_err}),
          32'({1'b1, 4'd1, 1'b1, 1'b0, 4'd3, 1'b0}));
    wait_drain();

    // Table vectors back-to-back: one command per cycle
    c0 = cyc;
    for (int i = 0; i < 9; i++)
      send_cmd(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].ci,
               mk(vecs[i].e_alu, vecs[i].e_c, vecs[i].e_z, vecs[i].op, vecs[i].e_err));
    check("throughput_cycles", cyc - c0, 9);
    wait_drain();

    // Back-pressure: only DEPTH accepted while rsp_ready is low
    pulse_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_cmd(4'd3, 4'(i), 4'd1, 1'b0, mk(4'(i + 1), 1'b0, 1'b0, 4'd3, 1'b0));
    fork
      begin
        send_cmd(4'd0, 4'd0, 4'd11, 1'b0, mk(4'd11, 1'b0, 1'b0, 4'd0, 1'b0));
        send_cmd(4'd5, 4'd6, 4'd3,  1'b0, mk(4'd5,  1'b0, 1'b0, 4'd5, 1'b0));
      end
      begin
        repeat (3) begin
          @(negedge clk_tb);
          check("bp_cmd_ready_low", 32'(cmd_ready), 0);
        end
        check("bp_issue_cnt_4", 32'(issue_cnt), 4);
        @(posedge clk_tb); #1;
        rsp_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_issue_cnt_6", 32'(issue_cnt), 6);

    // Illegal opcode is ordered with its neighbours and never issued
    v0 = vin_cnt;
    send_cmd(4'd4,  4'd3, 4'd5, 1'b0, mk(4'd14, 1'b1, 1'b0, 4'd4,  1'b0));
    send_cmd(4'd14, 4'd1, 4'd2, 1'b0, mk(4'd0,  1'b0, 1'b1, 4'd14, 1'b1));
    send_cmd(4'd5,  4'd6, 4'd5, 1'b0, mk(4'd3,  1'b0, 1'b0, 4'd5,  1'b0));
    wait_drain();
    check("illegal_valid_in_cycles", vin_cnt - v0, 2);
    check("illegal_no_proto_err", 32'(proto_err), 0);

    // Missing result for an issued INC
    send_cmd(4'd1, 4'd4, 4'd0, 1'b0, mk(4'd0, 1'b0, 1'b0, 4'd1, 1'b1));
    drop = 1'b1;
    repeat (2) @(posedge clk_tb);
    #1 drop = 1'b0;
    check("missing_proto_err", 32'(proto_err), 1);
    send_cmd(4'd2, 4'd4, 4'd0, 1'b0, mk(4'd3, 1'b0, 1'b0, 4'd2, 1'b0));
    wait_drain();
    check("missing_proto_sticky", 32'(proto_err), 1);

    // Asynchronous reset with commands in flight
    send_cmd(4'd0, 4'd0, 4'd1, 1'b0, mk(4'd1, 1'b0, 1'b0, 4'd0, 1'b0));
    send_cmd(4'd0, 4'd0, 4'd2, 1'b0, mk(4'd2, 1'b0, 1'b0, 4'd0, 1'b0));
    send_cmd(4'd0, 4'd0, 4'd3, 1'b0, mk(4'd3, 1'b0, 1'b0, 4'd0, 1'b0));
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_outputs", 32'({valid_in, rsp_valid, proto_err, cmd_ready}), 0);
    check("midrst_issue_cnt", 32'(issue_cnt), 0);
    repeat (2) @(posedge clk_tb);
    #3 reset = 1'b0;
    spur = 1'b1;
    @(posedge clk_tb); #1;
    spur = 1'b0;
    @(negedge clk_tb);
    check("postrst_ignore_window", 32'(proto_err), 0);
    @(posedge clk_tb); #1;
    send_cmd(4'd0, 4'd2, 4'd7, 1'b0, mk(4'd7, 1'b0, 1'b0, 4'd0, 1'b0));
    wait_drain();
    check("postrst_issue_cnt", 32'(issue_cnt), 1);
    check("postrst_no_proto_err", 32'(proto_err), 0);

    // Spurious valid_out with nothing issued
    spur = 1'b1;
    @(posedge clk_tb); #1;
    spur = 1'b0;
    check("spur_proto_err", 32'(proto_err), 1);
    check("spur_no_push", 32'(rsp_valid), 0);
    repeat (3) @(posedge clk_tb);
    #1;
    check("spur_proto_sticky", 32'(proto_err), 1);
    check("spur_still_empty", 32'(rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
